// File: rtl/ysyx_22050243_ifu_fetchq.sv
// Instruction-fetch front end: PC, in-order requests and the IF->ID fetch queue.
// Request credits guarantee every response a queue slot; redirects drop stale responses.
module ysyx_22050243_ifu_fetchq #(
    parameter int                    ADDR_WIDTH = 64,
    parameter int                    INST_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 64'h0000_0000_8000_0000,
    parameter int                    FQ_DEPTH   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      inst_req_valid_o,
    input  logic                      inst_req_ready_i,
    output logic [ADDR_WIDTH-1:0]     inst_addr_o,
    input  logic                      i_inst_valid,
    input  logic [INST_WIDTH-1:0]     i_inst,
    input  logic                      redirect_i,
    input  logic [ADDR_WIDTH-1:0]     redirect_pc_i,
    output logic                      id_valid_o,
    input  logic                      id_ready_i,
    output logic [INST_WIDTH-1:0]     id_inst_o,
    output logic [ADDR_WIDTH-1:0]     id_pc_o,
    output logic [$clog2(FQ_DEPTH):0] fq_count_o
);

    localparam int PW = $clog2(FQ_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW+1:0] DEPTH_W = (CW+2)'(FQ_DEPTH);

    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] inf_pc [FQ_DEPTH];
    logic [PW-1:0]         inf_wr;
    logic [PW-1:0]         inf_rd;
    logic [CW-1:0]         inflight_cnt;
    logic [CW-1:0]         drop_cnt;

    logic [INST_WIDTH-1:0] fq_inst [FQ_DEPTH];
    logic [ADDR_WIDTH-1:0] fq_pc [FQ_DEPTH];
    logic [PW-1:0]         fq_wr;
    logic [PW-1:0]         fq_rd;
    logic [CW-1:0]         fq_cnt;

    logic [CW+1:0] used;
    logic          req_fire;
    logic          rsp_drop;
    logic          rsp_take;
    logic          rsp_any;
    logic          pop;

    assign used = (CW+2)'(inflight_cnt) + (CW+2)'(drop_cnt)
                + (CW+2)'(fq_cnt);

    // Gating with rst keeps the request line low for the whole reset pulse.
    assign inst_req_valid_o = rst && !redirect_i && (used < DEPTH_W);
    assign inst_addr_o      = pc;
    assign req_fire         = inst_req_valid_o && inst_req_ready_i;

    assign rsp_drop = i_inst_valid && (drop_cnt != '0);
    assign rsp_take = i_inst_valid && (drop_cnt == '0)
                   && (inflight_cnt != '0);
    assign rsp_any  = rsp_drop || rsp_take;

    assign id_valid_o = (fq_cnt != '0);
    assign pop        = id_valid_o && id_ready_i;
    assign id_inst_o  = id_valid_o ? fq_inst[fq_rd] : '0;
    assign id_pc_o    = id_valid_o ? fq_pc[fq_rd] : '0;
    assign fq_count_o = fq_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc           <= RESET_PC;
            inf_wr       <= '0;
            inf_rd       <= '0;
            inflight_cnt <= '0;
            drop_cnt     <= '0;
            fq_wr        <= '0;
            fq_rd        <= '0;
            fq_cnt       <= '0;
        end else if (redirect_i) begin
            pc           <= redirect_pc_i & ~ADDR_WIDTH'(3);
            inf_wr       <= '0;
            inf_rd       <= '0;
            inflight_cnt <= '0;
            drop_cnt     <= drop_cnt + inflight_cnt - CW'(rsp_any);
            fq_wr        <= '0;
            fq_rd        <= '0;
            fq_cnt       <= '0;
        end else begin
            if (req_fire) begin
                pc     <= pc + ADDR_WIDTH'(4);
                inf_wr <= inf_wr + 1'b1;
            end
            if (rsp_take) begin
                inf_rd <= inf_rd + 1'b1;
                fq_wr  <= fq_wr + 1'b1;
            end
            if (rsp_drop) begin
                drop_cnt <= drop_cnt - 1'b1;
            end
            if (pop) begin
                fq_rd <= fq_rd + 1'b1;
            end
            inflight_cnt <= inflight_cnt + CW'(req_fire) - CW'(rsp_take);
            fq_cnt       <= fq_cnt + CW'(rsp_take) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) begin
            inf_pc[inf_wr] <= pc;
        end
        if (rsp_take && !redirect_i) begin
            fq_inst[fq_wr] <= i_inst;
            fq_pc[fq_wr]   <= inf_pc[inf_rd];
        end
    end

endmodule

// File: tb/tb_ysyx_22050243_ifu_fetchq.sv
// Directed bench for the fetch queue with a latency-configurable memory model.
// A second instance starts near the top of the address space to cover PC wrap.
module tb_ysyx_22050243_ifu_fetchq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_req_valid_o;
    logic        inst_req_ready_i = 1'b0;
    logic [63:0] inst_addr_o;
    logic        i_inst_valid = 1'b0;
    logic [31:0] i_inst = '0;
    logic        redirect_i = 1'b0;
    logic [63:0] redirect_pc_i = '0;
    logic        id_valid_o;
    logic        id_ready_i = 1'b0;
    logic [31:0] id_inst_o;
    logic [63:0] id_pc_o;
    logic [2:0]  fq_count_o;

    logic        w_req_valid;
    logic [63:0] w_addr;
    logic        w_id_valid;
    logic [31:0] w_id_inst;
    logic [63:0] w_id_pc;
    logic [2:0]  w_fq_count;

    typedef struct {
        logic [63:0] addr;
        int          due;
    } pend_t;

    pend_t       pend [$];
    logic [63:0] req_log [$];
    logic [63:0] id_log [$];
    int          cyc = 0;
    int          lat = 1;
    int          first_acc = -1;
    int          first_idv = -1;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    ysyx_22050243_ifu_fetchq u_dut (
        .clk              (clk),
        .rst              (rst),
        .inst_req_valid_o (inst_req_valid_o),
        .inst_req_ready_i (inst_req_ready_i),
        .inst_addr_o      (inst_addr_o),
        .i_inst_valid     (i_inst_valid),
        .i_inst           (i_inst),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i),
        .id_valid_o       (id_valid_o),
        .id_ready_i       (id_ready_i),
        .id_inst_o        (id_inst_o),
        .id_pc_o          (id_pc_o),
        .fq_count_o       (fq_count_o)
    );

    ysyx_22050243_ifu_fetchq #(
        .RESET_PC (64'hFFFF_FFFF_FFFF_FFFC)
    ) u_wrap (
        .clk              (clk),
        .rst              (rst),
        .inst_req_valid_o (w_req_valid),
        .inst_req_ready_i (1'b1),
        .inst_addr_o      (w_addr),
        .i_inst_valid     (1'b0),
        .i_inst           (32'h0),
        .redirect_i       (1'b0),
        .redirect_pc_i    (64'h0),
        .id_valid_o       (w_id_valid),
        .id_ready_i       (1'b0),
        .id_inst_o        (w_id_inst),
        .id_pc_o          (w_id_pc),
        .fq_count_o       (w_fq_count)
    );

    function automatic logic [31:0] mk_inst(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        pend_t e;
        cyc++;
        if (rst) begin
            if (i_inst_valid && pend.size() > 0) begin
                e = pend.pop_front();
            end
            if (inst_req_valid_o && inst_req_ready_i) begin
                e.addr = inst_addr_o;
                e.due  = cyc + lat;
                pend.push_back(e);
                req_log.push_back(inst_addr_o);
                if (first_acc < 0) first_acc = cyc - 1;
            end
            if (id_valid_o && id_ready_i) begin
                id_log.push_back(id_pc_o);
                chk("id_inst", {32'h0, id_inst_o}, {32'h0, mk_inst(id_pc_o)});
            end
        end
    end

    always @(negedge clk) begin
        if (rst && pend.size() > 0 && pend[0].due <= cyc + 1) begin
            i_inst_valid = 1'b1;
            i_inst       = mk_inst(pend[0].addr);
        end else begin
            i_inst_valid = 1'b0;
            i_inst       = '0;
        end
        if (id_valid_o && first_idv < 0) first_idv = cyc;
    end

    task automatic do_reset(input int l, input logic rdy, input logic idr);
        @(negedge clk);
        rst              = 1'b0;
        redirect_i       = 1'b0;
        lat              = l;
        inst_req_ready_i = rdy;
        id_ready_i       = idr;
        pend.delete();
        req_log.delete();
        id_log.delete();
        first_acc        = -1;
        first_idv        = -1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #1 rst = 1'b0;
        #1;
        chk("rst_req_valid", {63'h0, inst_req_valid_o}, 64'h0);
        chk("rst_id_valid", {63'h0, id_valid_o}, 64'h0);
        chk("rst_id_pc", id_pc_o, 64'h0);
        chk("rst_id_inst", {32'h0, id_inst_o}, 64'h0);
        chk("rst_fq_count", {61'h0, fq_count_o}, 64'h0);
        chk("rst_addr", inst_addr_o, 64'h8000_0000);

        // basic streaming fetch
        do_reset(1, 1'b1, 1'b1);
        repeat (10) @(negedge clk);
        chk("t1_req_n", 64'(req_log.size()), 64'd10);
        chk("t1_id_n", 64'(id_log.size()), 64'd8);
        chk("t1_latency", 64'(first_idv - first_acc), 64'd2);
        for (int i = 0; i < 3; i++) begin
            chk("t1_req_addr", req_log[i], 64'h8000_0000 + 64'(4 * i));
            chk("t1_id_pc", id_log[i], 64'h8000_0000 + 64'(4 * i));
        end

        // backpressure until the queue is full, then drain
        do_reset(1, 1'b1, 1'b0);
        repeat (8) @(negedge clk);
        #1;
        chk("t2_req_n", 64'(req_log.size()), 64'd4);
        chk("t2_req_valid", {63'h0, inst_req_valid_o}, 64'h0);
        chk("t2_fq_count", {61'h0, fq_count_o}, 64'd4);
        chk("t2_head_pc", id_pc_o, 64'h8000_0000);
        repeat (2) @(negedge clk);
        chk("t2_head_hold", id_pc_o, 64'h8000_0000);
        id_ready_i = 1'b1;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("t2_drain_pc", id_log[i], 64'h8000_0000 + 64'(4 * i));
        end
        chk("t2_resume", req_log[4], 64'h8000_0010);

        // redirect with two requests in flight
        do_reset(3, 1'b1, 1'b1);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        redirect_i    = 1'b1;
        redirect_pc_i = 64'h8000_0100;
        #1;
        chk("t3_no_req", {63'h0, inst_req_valid_o}, 64'h0);
        @(negedge clk);
        redirect_i = 1'b0;
        #1;
        chk("t3_addr", inst_addr_o, 64'h8000_0100);
        repeat (12) @(negedge clk);
        chk("t3_req2", req_log[2], 64'h8000_0100);
        chk("t3_id0", id_log[0], 64'h8000_0100);
        chk("t3_id1", id_log[1], 64'h8000_0104);

        // redirect, response and pop in one cycle with one more in flight
        do_reset(2, 1'b1, 1'b1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        #1;
        chk("t4_pre_count", {61'h0, fq_count_o}, 64'd1);
        chk("t4_pre_head", id_pc_o, 64'h8000_0004);
        redirect_i    = 1'b1;
        redirect_pc_i = 64'h8000_0200;
        @(negedge clk);
        redirect_i = 1'b0;
        #1;
        chk("t4_fq_count", {61'h0, fq_count_o}, 64'd0);
        chk("t4_id_valid", {63'h0, id_valid_o}, 64'h0);
        chk("t4_drop_cnt", {61'h0, u_dut.drop_cnt}, 64'd1);
        chk("t4_id_n", 64'(id_log.size()), 64'd2);
        repeat (10) @(negedge clk);
        chk("t4_id1", id_log[1], 64'h8000_0004);
        chk("t4_id2", id_log[2], 64'h8000_0200);
        chk("t4_id3", id_log[3], 64'h8000_0204);

        // misaligned redirect target and PC wrap
        do_reset(1, 1'b0, 1'b0);
        #1;
        chk("t5_wrap_first", w_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("t5_wrap_valid", {63'h0, w_req_valid}, 64'h1);
        @(negedge clk);
        #1;
        chk("t5_wrap_second", w_addr, 64'h0);
        redirect_i    = 1'b1;
        redirect_pc_i = 64'h8000_0102;
        @(negedge clk);
        redirect_i = 1'b0;
        #1;
        chk("t5_align", inst_addr_o, 64'h8000_0100);

        // asynchronous reset with the queue half full
        do_reset(1, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        chk("t6_pre_count", {61'h0, fq_count_o}, 64'd2);
        #1 rst = 1'b0;
        #1;
        chk("t6_req_valid", {63'h0, inst_req_valid_o}, 64'h0);
        chk("t6_id_valid", {63'h0, id_valid_o}, 64'h0);
        chk("t6_id_inst", {32'h0, id_inst_o}, 64'h0);
        chk("t6_id_pc", id_pc_o, 64'h0);
        chk("t6_fq_count", {61'h0, fq_count_o}, 64'h0);
        chk("t6_addr", inst_addr_o, 64'h8000_0000);
        pend.delete();
        req_log.delete();
        id_log.delete();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_req_n", 64'(req_log.size()), 64'd1);
        chk("t6_first_req", req_log[0], 64'h8000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_22050243_ifu_fetchq.md
Name: ysyx_22050243_ifu_fetchq

Overview:
- Parametrised instruction-fetch front end for the 5-stage core, replacing the bare PC register and IF→ID slice.
- Holds the PC and issues in-order instruction requests with a valid/ready handshake.
- Tolerates variable response latency and buffers fetched {inst, pc} pairs in a FQ_DEPTH-entry fetch queue feeding ID.
- On a branch/jump redirect, discards wrong-path responses that are still in flight.

Parameters:
ADDR_WIDTH  64  instruction address / PC width
INST_WIDTH  32  instruction-bus data width
RESET_PC  64'h0000_0000_8000_0000  PC after reset
FQ_DEPTH  4  fetch-queue entries and maximum outstanding requests; power of 2, >=2

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (asserted at 0)
inst_req_valid_o  out  1  request valid
inst_req_ready_i  in  1  memory accepts request
inst_addr_o  out  ADDR_WIDTH  request address (current PC)
i_inst_valid  in  1  response valid, in request order, one per accepted request
i_inst  in  INST_WIDTH  response data
redirect_i  in  1  branch/jump redirect (single-cycle pulse)
redirect_pc_i  in  ADDR_WIDTH  redirect target
id_valid_o  out  1  fetch-queue head valid
id_ready_i  in  1  ID accepts head (0 = pipeline stall)
id_inst_o  out  INST_WIDTH  head instruction
id_pc_o  out  ADDR_WIDTH  head PC
fq_count_o  out  $clog2(FQ_DEPTH)+1  current fetch-queue occupancy

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=RESET_PC.
  - Fetch queue, in-flight PC FIFO, inflight_cnt, drop_cnt and fq_count all 0.
  - inst_req_valid_o=0, id_valid_o=0, id_inst_o=0, id_pc_o=0.
  - Reset asserted mid-operation abandons all state; any responses arriving later for pre-reset requests are the memory side's responsibility.
- Counters are $clog2(FQ_DEPTH)+1 bits wide.
- Credit rule:
  - inst_req_valid_o = !redirect_i && (inflight_cnt + drop_cnt + fq_count < FQ_DEPTH).
  - This guarantees every response finds a free queue slot, so responses are never back-pressured.
- inst_addr_o = pc (combinational from the register).
- Request accept (valid && ready):
  - Push pc into the in-flight PC FIFO.
  - inflight_cnt++.
  - pc <= pc+4, wrapping modulo 2^ADDR_WIDTH.
- Response (i_inst_valid):
  - If drop_cnt>0: discard the response, drop_cnt--.
  - Otherwise: pop the in-flight PC FIFO, push {i_inst, popped pc} into the fetch queue, inflight_cnt--.
  - A response with inflight_cnt==0 and drop_cnt==0 is illegal: it is ignored and no counter underflows.
- ID handshake:
  - id_valid_o = (fq_count!=0); head outputs are combinational from the queue head.
  - Pop when id_valid_o && id_ready_i.
  - Head data is stable while id_ready_i=0.
  - Push and pop in the same cycle leave fq_count unchanged; push into an empty queue becomes visible the next cycle (1-cycle response→ID latency).
- Redirect (redirect_i=1) takes priority over everything in the same cycle:
  - pc <= {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00}; low bits are forced to zero.
  - Fetch queue flushed (fq_count<=0); a same-cycle pop has no additional effect.
  - In-flight PC FIFO cleared, inflight_cnt<=0.
  - drop_cnt <= drop_cnt + inflight_cnt − (i_inst_valid ? 1 : 0): the same-cycle response is discarded and counted against the drop count.
  - No request is issued that cycle.
  - Back-to-back redirects: the last one wins, and drop_cnt accumulates correctly.
- Steady state, with inst_req_ready_i=1, 1-cycle response latency and id_ready_i=1: one instruction per cycle, no bubbles.
- Boundary conditions:
  - Queue full: no requests issued; head held stable.
  - Queue empty: id_valid_o=0.
  - Both FIFO pointers wrap modulo FQ_DEPTH.

Test Plan:
1. Basic fetch: release reset; ready=1, 1-cycle responses, id_ready=1 → requests at 0x80000000, 0x80000004, 0x80000008; ID sees pc/inst in the same order; id_valid_o first rises 2 cycles after the first request accept.
2. Backpressure: FQ_DEPTH=4, id_ready=0 → exactly 4 requests accepted, then inst_req_valid_o=0; fq_count_o=4; head pc stays 0x80000000. Raise id_ready → pcs 0x80000000..0x8000000C drain in order and requests resume.
3. Redirect with 2 in flight (3-cycle response latency), redirect_pc_i=0x80000100 → next request address is 0x80000100; both old responses are dropped; first id_pc_o is 0x80000100.
4. Simultaneous events: redirect, a response and an ID pop in the same cycle, 1 other request in flight → queue empties, drop_cnt=1, and no stale instruction ever reaches ID.
5. Misaligned target: redirect_pc_i=0x80000102 → inst_addr_o=0x80000100. PC wrap: RESET_PC=64'hFFFF_FFFF_FFFF_FFFC → second request address is 0.
6. Async reset mid-run with queue half full → all outputs 0 immediately, without waiting for a clock edge; after release, the first request is at RESET_PC.
